// File: rtl/sha_core_arbiter.sv
// Round-robin scheduler sharing one SHA-256 core between two requesters.
// Each job resets the core, starts it once, guards it with a watchdog and returns the digest.
module sha_core_arbiter #(
    parameter int TIMEOUT_CYC = 20000,
    parameter int TMR_W       = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic [511:0] req0_data,
    input  logic [7:0]   req0_nblk,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [511:0] req1_data,
    input  logic [7:0]   req1_nblk,
    output logic         req1_ready,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [255:0] rsp0_digest,
    output logic         rsp0_err,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [255:0] rsp1_digest,
    output logic         rsp1_err,
    output logic         core_rst_n,
    output logic         core_enable,
    output logic [511:0] core_data,
    output logic [7:0]   core_n,
    input  logic         core_done,
    input  logic [255:0] core_digest
);

    typedef enum logic [2:0] {IDLE, CLR, START, WAIT, CAPT, RESP} state_e;

    localparam logic [TMR_W-1:0] WDOG_LAST = TMR_W'(TIMEOUT_CYC - 1);

    state_e            state_q;
    logic              gnt_q;
    logic              last_grant_q;
    logic [TMR_W-1:0]  wdog_q;
    logic [1:0]        req_ready_q;
    logic [1:0]        rsp_valid_q;
    logic [1:0]        rsp_err_q;
    logic [1:0][255:0] rsp_digest_q;
    logic              core_rst_n_q;
    logic              core_enable_q;
    logic [511:0]      core_data_q;
    logic [7:0]        core_n_q;

    logic              gnt_d;
    logic [511:0]      acc_data_d;
    logic [7:0]        acc_nblk_d;
    logic [1:0]        rsp_ready_w;

    // On a tie the port that did not win last time gets the grant.
    assign gnt_d       = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign acc_data_d  = gnt_d ? req1_data : req0_data;
    assign acc_nblk_d  = gnt_d ? req1_nblk : req0_nblk;
    assign rsp_ready_w = {rsp1_ready, rsp0_ready};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            gnt_q         <= 1'b0;
            last_grant_q  <= 1'b1;
            wdog_q        <= '0;
            req_ready_q   <= '0;
            rsp_valid_q   <= '0;
            rsp_err_q     <= '0;
            rsp_digest_q  <= '0;
            core_rst_n_q  <= 1'b0;
            core_enable_q <= 1'b0;
            core_data_q   <= '0;
            core_n_q      <= '0;
        end else begin
            req_ready_q   <= '0;
            core_enable_q <= 1'b0;
            core_rst_n_q  <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        gnt_q              <= gnt_d;
                        req_ready_q[gnt_d] <= 1'b1;
                        core_data_q        <= acc_data_d;
                        core_n_q           <= acc_nblk_d;
                        // A zero block count would wrap the core's last-block compare; reject it untouched.
                        if (acc_nblk_d == 8'd0) begin
                            rsp_valid_q[gnt_d]  <= 1'b1;
                            rsp_err_q[gnt_d]    <= 1'b1;
                            rsp_digest_q[gnt_d] <= '0;
                            state_q             <= RESP;
                        end else begin
                            core_rst_n_q <= 1'b0;
                            state_q      <= CLR;
                        end
                    end
                end
                CLR: begin
                    core_enable_q <= 1'b1;
                    state_q       <= START;
                end
                START: begin
                    wdog_q  <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    wdog_q <= wdog_q + TMR_W'(1);
                    if (core_done) begin
                        state_q <= CAPT;
                    end else if (wdog_q == WDOG_LAST) begin
                        rsp_valid_q[gnt_q]  <= 1'b1;
                        rsp_err_q[gnt_q]    <= 1'b1;
                        rsp_digest_q[gnt_q] <= '0;
                        state_q             <= RESP;
                    end
                end
                CAPT: begin
                    rsp_valid_q[gnt_q]  <= 1'b1;
                    rsp_err_q[gnt_q]    <= 1'b0;
                    rsp_digest_q[gnt_q] <= core_digest;
                    state_q             <= RESP;
                end
                RESP: begin
                    if (rsp_ready_w[gnt_q]) begin
                        rsp_valid_q[gnt_q] <= 1'b0;
                        last_grant_q       <= gnt_q;
                        state_q            <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req0_ready  = req_ready_q[0];
    assign req1_ready  = req_ready_q[1];
    assign rsp0_valid  = rsp_valid_q[0];
    assign rsp1_valid  = rsp_valid_q[1];
    assign rsp0_digest = rsp_digest_q[0];
    assign rsp1_digest = rsp_digest_q[1];
    assign rsp0_err    = rsp_err_q[0];
    assign rsp1_err    = rsp_err_q[1];
    assign core_rst_n  = core_rst_n_q;
    assign core_enable = core_enable_q;
    assign core_data   = core_data_q;
    assign core_n      = core_n_q;

endmodule
